vending_ctrl_p: RTL and testbench
=================================

VENDING_CTRL_P -- requirements
Module: vending_ctrl_p

Interface
REQ-001 Parameter VALUE_W, default 8, width of coin values and credit.
REQ-002 Parameter N_ITEMS, default 4, number of selectable products.
REQ-003 Parameter PRICE, default 25, price of every product.
REQ-004 Parameter MAX_CREDIT, default 100, upper bound on accumulated credit.
REQ-005 Parameter CHANGE_COIN, default 5, value of one returned coin.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 coin_valid  input  1  one-cycle strobe, coin inserted.
REQ-009 coin_value  input  VALUE_W  value of inserted coin, sampled with coin_valid.
REQ-010 sel_valid  input  1  one-cycle strobe, product selected.
REQ-011 sel_item  input  clog2(N_ITEMS), min 1  selected product index.
REQ-012 cancel  input  1  one-cycle strobe, refund request.
REQ-013 stock_empty  input  N_ITEMS  per-product sold-out flags.
REQ-014 change_ready  input  1  coin hopper accepts one coin this cycle.
REQ-015 dispense_valid  output  1  one-cycle pulse, release product.
REQ-016 dispense_item  output  clog2(N_ITEMS), min 1  product index, valid with dispense_valid.
REQ-017 change_valid  output  1  one coin of CHANGE_COIN offered to hopper.
REQ-018 coin_reject  output  1  one-cycle pulse, inserted coin returned unaccepted.
REQ-019 sel_reject  output  1  one-cycle pulse, selection refused.
REQ-020 credit  output  VALUE_W  current accumulated credit.
REQ-021 state  output  4  one-hot state: EAT=0001, VEND=0010, CHANGE=0100, REFUND=1000.

Function
REQ-022 All outputs SHALL be registered; every pulse/response appears the cycle after the causing input.
REQ-023 Input priority in EAT SHALL be: cancel > sel_valid > coin_valid.
REQ-024 EAT, cancel: credit>0 -> REFUND; credit=0 -> stay EAT, no pulse.
REQ-025 EAT, sel_valid, credit>=PRICE and stock_empty[sel_item]=0 -> VEND, latch sel_item into dispense_item.
REQ-026 EAT, sel_valid otherwise (credit<PRICE, sold out, or sel_item>=N_ITEMS) -> sel_reject pulse, stay EAT, credit unchanged.
REQ-027 EAT, coin_valid alone: credit+coin_value (computed in VALUE_W+1 bits) <= MAX_CREDIT -> credit += coin_value; else coin_reject pulse, credit unchanged.
REQ-028 coin_valid coincident with accepted cancel/sel, or in any non-EAT state, SHALL produce coin_reject and no credit change.
REQ-029 sel_valid or cancel in non-EAT states SHALL be ignored silently.
REQ-030 VEND SHALL last exactly one cycle: dispense_valid=1, credit -= PRICE; next state CHANGE if remainder>0, else EAT.
REQ-031 CHANGE and REFUND: change_valid=1 while credit>0; each cycle with change_valid and change_ready, credit -= min(CHANGE_COIN, credit).
REQ-032 Handshake completing with credit reaching 0 SHALL deassert change_valid next cycle and enter EAT.
REQ-033 change_valid SHALL stay high and credit stable while change_ready=0 (no timeout).
REQ-034 Unreachable state encodings SHALL recover to EAT with credit cleared on the next edge.

Reset
REQ-035 rst=1 SHALL immediately force state=0001, credit=0, dispense_valid=0, change_valid=0, coin_reject=0, sel_reject=0, dispense_item=0, independent of clk.
REQ-036 Reset asserted mid-VEND/CHANGE/REFUND SHALL abort the transaction; credit is discarded, no further pulses.

Verification
REQ-037 Coins 10,10,5 then sel 2 (stock ok) -> credit 25, VEND, dispense_valid one cycle with item 2, credit 0, back to EAT, no change_valid.
REQ-038 Coins 25,10,5 then sel 0, change_ready stalled 3 cycles then high -> credit 15, three change_valid handshakes, credit 15->10->5->0, EAT.
REQ-039 Credit 95, coin 10 -> coin_reject pulse, credit 95; coin 5 -> credit 100.
REQ-040 Credit 20, sel 1 -> sel_reject; credit 30, sel 3 with stock_empty[3]=1 -> sel_reject, credit 30; cancel -> REFUND, six coins, EAT.
REQ-041 Same cycle cancel+sel+coin at credit 25 -> REFUND, coin_reject, no dispense.
REQ-042 rst asserted between clock edges during CHANGE with credit 10 -> outputs cleared before next edge, state 0001, credit 0.

Source files
------------

// File: rtl/vending_ctrl_p.sv
// Vending machine controller: accumulates coin credit, vends one product, pays change/refunds coin by coin.
// Latency: every output is registered; each response appears one cycle after the input that caused it.
// Backpressure: change_valid holds with credit stable until change_ready; strobes outside EAT are refused or ignored.
module vending_ctrl_p #(
   parameter int VALUE_W     = 8,
   parameter int N_ITEMS     = 4,
   parameter int PRICE       = 25,
   parameter int MAX_CREDIT  = 100,
   parameter int CHANGE_COIN = 5,
   localparam int SEL_W      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               coin_valid,
   input  logic [VALUE_W-1:0] coin_value,
   input  logic               sel_valid,
   input  logic [SEL_W-1:0]   sel_item,
   input  logic               cancel,
   input  logic [N_ITEMS-1:0] stock_empty,
   input  logic               change_ready,
   output logic               dispense_valid,
   output logic [SEL_W-1:0]   dispense_item,
   output logic               change_valid,
   output logic               coin_reject,
   output logic               sel_reject,
   output logic [VALUE_W-1:0] credit,
   output logic [3:0]         state
);

   typedef enum logic [3:0] {
      EAT    = 4'b0001,
      VEND   = 4'b0010,
      CHANGE = 4'b0100,
      REFUND = 4'b1000
   } state_t;

   localparam logic [VALUE_W:0]   MAX_X   = (VALUE_W+1)'(MAX_CREDIT);
   localparam logic [VALUE_W-1:0] PRICE_V = VALUE_W'(PRICE);
   localparam logic [VALUE_W-1:0] COIN_V  = VALUE_W'(CHANGE_COIN);

   state_t             state_q, nxt_state;
   logic [VALUE_W-1:0] credit_q, nxt_credit;
   logic [SEL_W-1:0]   item_q, nxt_item;
   logic               nxt_dv, nxt_cv, nxt_crj, nxt_srj;

   // Sum is one bit wider so an overflowing coin is caught rather than wrapped.
   logic [VALUE_W:0]   coin_sum;
   logic [VALUE_W-1:0] remain;
   logic [VALUE_W-1:0] give;
   logic               sel_ok;

   assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value};
   assign remain   = credit_q - PRICE_V;
   assign give     = (credit_q < COIN_V) ? credit_q : COIN_V;
   assign sel_ok   = (32'(sel_item) < N_ITEMS) && (credit_q >= PRICE_V) && !stock_empty[sel_item];

   assign dispense_item = item_q;
   assign credit        = credit_q;
   assign state         = state_q;

   // State, credit and all output pulses are registered here; reset clears them asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= EAT;
         credit_q       <= '0;
         item_q         <= '0;
         dispense_valid <= 1'b0;
         change_valid   <= 1'b0;
         coin_reject    <= 1'b0;
         sel_reject     <= 1'b0;
      end else begin
         state_q        <= nxt_state;
         credit_q       <= nxt_credit;
         item_q         <= nxt_item;
         dispense_valid <= nxt_dv;
         change_valid   <= nxt_cv;
         coin_reject    <= nxt_crj;
         sel_reject     <= nxt_srj;
      end
   end

   // Next-state and next-output decode; in EAT cancel outranks selection, which outranks coins.
   always_comb begin
      nxt_state  = state_q;
      nxt_credit = credit_q;
      nxt_item   = item_q;
      nxt_dv     = 1'b0;
      nxt_cv     = 1'b0;
      nxt_crj    = 1'b0;
      nxt_srj    = 1'b0;
      case (state_q)
         EAT: begin
            if (cancel && (credit_q != '0)) begin
               nxt_state = REFUND;
               nxt_cv    = 1'b1;
               nxt_crj   = coin_valid;
            end else if (sel_valid) begin
               // A coin arriving alongside any selection is handed back untouched.
               nxt_crj = coin_valid;
               if (sel_ok) begin
                  nxt_state = VEND;
                  nxt_item  = sel_item;
                  nxt_dv    = 1'b1;
               end else begin
                  nxt_srj = 1'b1;
               end
            end else if (coin_valid) begin
               if (coin_sum <= MAX_X) begin
                  nxt_credit = coin_sum[VALUE_W-1:0];
               end else begin
                  nxt_crj = 1'b1;
               end
            end
         end
         VEND: begin
            nxt_crj    = coin_valid;
            nxt_credit = remain;
            if (remain != '0) begin
               nxt_state = CHANGE;
               nxt_cv    = 1'b1;
            end else begin
               nxt_state = EAT;
            end
         end
         CHANGE, REFUND: begin
            nxt_crj = coin_valid;
            if (credit_q == '0) begin
               nxt_state = EAT;
            end else if (change_valid && change_ready) begin
               nxt_credit = credit_q - give;
               if (credit_q == give) begin
                  nxt_state = EAT;
               end else begin
                  nxt_cv = 1'b1;
               end
            end else begin
               nxt_cv = 1'b1;
            end
         end
         default: begin
            nxt_state  = EAT;
            nxt_credit = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_vending_ctrl_p.sv
// Directed bench for vending_ctrl_p with an expectation queue checked after each edge.
// Latency: expectations are checked #1 after the edge that should produce them.
// Backpressure: change_ready is driven low for a few cycles to stall the change payout.
module tb_vending_ctrl_p;

   localparam logic [3:0] S_EAT    = 4'b0001;
   localparam logic [3:0] S_VEND   = 4'b0010;
   localparam logic [3:0] S_CHANGE = 4'b0100;
   localparam logic [3:0] S_REFUND = 4'b1000;

   typedef struct packed {
      logic [3:0] st;
      logic [7:0] cr;
      logic       dv;
      logic [1:0] di;
      logic       cv;
      logic       crj;
      logic       srj;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       coin_valid;
   logic [7:0] coin_value;
   logic       sel_valid;
   logic [1:0] sel_item;
   logic       cancel;
   logic [3:0] stock_empty;
   logic       change_ready;
   logic       dispense_valid;
   logic [1:0] dispense_item;
   logic       change_valid;
   logic       coin_reject;
   logic       sel_reject;
   logic [7:0] credit;
   logic [3:0] state;

   exp_t  exp_q[$];
   string tag_q[$];
   int    total = 0;
   int    bad   = 0;

   vending_ctrl_p dut (
      .clk(clk), .rst(rst),
      .coin_valid(coin_valid), .coin_value(coin_value),
      .sel_valid(sel_valid), .sel_item(sel_item),
      .cancel(cancel), .stock_empty(stock_empty),
      .change_ready(change_ready),
      .dispense_valid(dispense_valid), .dispense_item(dispense_item),
      .change_valid(change_valid), .coin_reject(coin_reject),
      .sel_reject(sel_reject), .credit(credit), .state(state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t mk(logic [3:0] st, logic [7:0] cr, logic dv, logic [1:0] di,
                               logic cv, logic crj, logic srj);
      exp_t e;
      e.st = st; e.cr = cr; e.dv = dv; e.di = di; e.cv = cv; e.crj = crj; e.srj = srj;
      return e;
   endfunction

   task automatic cmp(input string t, input string f, input logic [7:0] got, input logic [7:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s.%s got=%0d exp=%0d", t, f, got, want);
      end
   endtask

   task automatic check_pop();
      exp_t  e;
      string t;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $error("FAIL scoreboard empty got=0 exp=1");
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         cmp(t, "state", {4'b0, state}, {4'b0, e.st});
         cmp(t, "credit", credit, e.cr);
         cmp(t, "dispense_valid", {7'b0, dispense_valid}, {7'b0, e.dv});
         if (e.dv) cmp(t, "dispense_item", {6'b0, dispense_item}, {6'b0, e.di});
         cmp(t, "change_valid", {7'b0, change_valid}, {7'b0, e.cv});
         cmp(t, "coin_reject", {7'b0, coin_reject}, {7'b0, e.crj});
         cmp(t, "sel_reject", {7'b0, sel_reject}, {7'b0, e.srj});
      end
   endtask

   // Check the outputs right now, without waiting for a clock edge.
   task automatic check_now(input string t, input exp_t e);
      exp_q.push_back(e);
      tag_q.push_back(t);
      check_pop();
   endtask

   // Queue the expectation for the current inputs, clock once, drop strobes, then check.
   task automatic tick(input string t, input exp_t e);
      exp_q.push_back(e);
      tag_q.push_back(t);
      @(posedge clk);
      #1;
      coin_valid = 1'b0;
      sel_valid  = 1'b0;
      cancel     = 1'b0;
      check_pop();
   endtask

   task automatic coin(input logic [7:0] v);
      coin_valid = 1'b1;
      coin_value = v;
   endtask

   task automatic sel(input logic [1:0] i);
      sel_valid = 1'b1;
      sel_item  = i;
   endtask

   initial begin
      int c;
      rst = 1'b1;
      coin_valid = 1'b0; coin_value = '0; sel_valid = 1'b0; sel_item = '0;
      cancel = 1'b0; stock_empty = '0; change_ready = 1'b1;
      #12;
      check_now("reset", mk(S_EAT, 0, 0, 0, 0, 0, 0));
      rst = 1'b0;

      // Exact price, no change
      coin(10); tick("c10", mk(S_EAT, 10, 0, 0, 0, 0, 0));
      coin(10); tick("c20", mk(S_EAT, 20, 0, 0, 0, 0, 0));
      coin(5);  tick("c25", mk(S_EAT, 25, 0, 0, 0, 0, 0));
      sel(2);   tick("vend2", mk(S_VEND, 25, 1, 2, 0, 0, 0));
      tick("vend2_done", mk(S_EAT, 0, 0, 0, 0, 0, 0));
      tick("vend2_idle", mk(S_EAT, 0, 0, 0, 0, 0, 0));

      // Vend with change, hopper stalled
      coin(25); tick("c25b", mk(S_EAT, 25, 0, 0, 0, 0, 0));
      coin(10); tick("c35", mk(S_EAT, 35, 0, 0, 0, 0, 0));
      coin(5);  tick("c40", mk(S_EAT, 40, 0, 0, 0, 0, 0));
      sel(0);   tick("vend0", mk(S_VEND, 40, 1, 0, 0, 0, 0));
      change_ready = 1'b0;
      tick("chg_enter", mk(S_CHANGE, 15, 0, 0, 1, 0, 0));
      for (int k = 0; k < 3; k++) tick("chg_stall", mk(S_CHANGE, 15, 0, 0, 1, 0, 0));
      change_ready = 1'b1;
      tick("chg10", mk(S_CHANGE, 10, 0, 0, 1, 0, 0));
      tick("chg5", mk(S_CHANGE, 5, 0, 0, 1, 0, 0));
      tick("chg0", mk(S_EAT, 0, 0, 0, 0, 0, 0));

      // Credit ceiling
      coin(25); tick("m25", mk(S_EAT, 25, 0, 0, 0, 0, 0));
      coin(25); tick("m50", mk(S_EAT, 50, 0, 0, 0, 0, 0));
      coin(25); tick("m75", mk(S_EAT, 75, 0, 0, 0, 0, 0));
      coin(20); tick("m95", mk(S_EAT, 95, 0, 0, 0, 0, 0));
      coin(10); tick("over", mk(S_EAT, 95, 0, 0, 0, 1, 0));
      coin(5);  tick("m100", mk(S_EAT, 100, 0, 0, 0, 0, 0));
      cancel = 1'b1; tick("refund100", mk(S_REFUND, 100, 0, 0, 1, 0, 0));
      for (int k = 1; k <= 20; k++) begin
         c = 100 - 5 * k;
         tick("refund100_pay", mk((c != 0) ? S_REFUND : S_EAT, 8'(c), 0, 0, c != 0, 0, 0));
      end

      // Selection refusals
      coin(20); tick("s20", mk(S_EAT, 20, 0, 0, 0, 0, 0));
      sel(1);   tick("rej_low", mk(S_EAT, 20, 0, 0, 0, 0, 1));
      tick("rej_low_clr", mk(S_EAT, 20, 0, 0, 0, 0, 0));
      coin(10); tick("s30", mk(S_EAT, 30, 0, 0, 0, 0, 0));
      stock_empty = 4'b1000;
      sel(3);   tick("rej_empty", mk(S_EAT, 30, 0, 0, 0, 0, 1));
      stock_empty = 4'b0000;
      cancel = 1'b1; tick("refund30", mk(S_REFUND, 30, 0, 0, 1, 0, 0));
      for (int k = 1; k <= 6; k++) begin
         c = 30 - 5 * k;
         tick("refund30_pay", mk((c != 0) ? S_REFUND : S_EAT, 8'(c), 0, 0, c != 0, 0, 0));
      end

      // Simultaneous cancel, select and coin
      coin(25); tick("p25", mk(S_EAT, 25, 0, 0, 0, 0, 0));
      cancel = 1'b1; sel(1); coin(5);
      tick("prio", mk(S_REFUND, 25, 0, 0, 1, 1, 0));
      coin(10); tick("coin_in_refund", mk(S_REFUND, 20, 0, 0, 1, 1, 0));
      tick("prio15", mk(S_REFUND, 15, 0, 0, 1, 0, 0));
      tick("prio10", mk(S_REFUND, 10, 0, 0, 1, 0, 0));
      tick("prio5", mk(S_REFUND, 5, 0, 0, 1, 0, 0));
      tick("prio0", mk(S_EAT, 0, 0, 0, 0, 0, 0));

      // Asynchronous reset in the middle of a change payout
      coin(25); tick("r25", mk(S_EAT, 25, 0, 0, 0, 0, 0));
      coin(10); tick("r35", mk(S_EAT, 35, 0, 0, 0, 0, 0));
      sel(2);   tick("rvend", mk(S_VEND, 35, 1, 2, 0, 0, 0));
      change_ready = 1'b0;
      tick("rchg", mk(S_CHANGE, 10, 0, 0, 1, 0, 0));
      #3 rst = 1'b1;
      #1 check_now("async_rst", mk(S_EAT, 0, 0, 0, 0, 0, 0));
      total++;
      assert (dispense_item === 2'd0) else begin
         bad++;
         $error("FAIL async_rst.dispense_item got=%0d exp=0", dispense_item);
      end
      #1 rst = 1'b0;
      change_ready = 1'b1;
      tick("post_rst", mk(S_EAT, 0, 0, 0, 0, 0, 0));
      cancel = 1'b1; tick("cancel_zero", mk(S_EAT, 0, 0, 0, 0, 0, 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
